// File: rtl/posit_normalize_pipe_if.sv
// Beat-level handshake bundle between the accumulator, the posit normaliser and the output serialiser.
// master drives the input beat and out_ready; slave is the normaliser.
interface posit_normalize_pipe_if #(
   parameter int NBITS = 32,
   parameter int SBITS = 10,
   parameter int FBITS = 252
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_sgn;
   logic signed [SBITS-1:0] in_scale;
   logic [FBITS-1:0]        in_fraction;
   logic                    in_truncated;
   logic                    in_inf;
   logic                    in_zero;
   logic                    out_valid;
   logic                    out_ready;
   logic [NBITS-1:0]        out_posit;
   logic                    out_inf;
   logic                    out_zero;
   logic                    out_saturated;

   modport master (
      output in_valid, in_sgn, in_scale, in_fraction, in_truncated, in_inf, in_zero, out_ready,
      input  in_ready, out_valid, out_posit, out_inf, out_zero, out_saturated
   );

   modport slave (
      input  in_valid, in_sgn, in_scale, in_fraction, in_truncated, in_inf, in_zero, out_ready,
      output in_ready, out_valid, out_posit, out_inf, out_zero, out_saturated
   );
endinterface

// File: rtl/posit_normalize_pipe.sv
// Converts sign/scale/wide-fraction into an NBITS/ES posit with clamping and round-nearest-even.
// Latency 3 cycles at 1 beat/cycle; a stage stalls only when the stage ahead is full and blocked.
module posit_normalize_pipe #(
   parameter int NBITS      = 32,
   parameter int ES         = 3,
   parameter int SBITS      = 10,
   parameter int FBITS      = 252,
   parameter int ROUND_MODE = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   posit_normalize_pipe_if.slave bus
);
   localparam int BW = 2 + ES + FBITS + NBITS - 1;
   localparam logic signed [SBITS-1:0] MAXSCALE = SBITS'((NBITS - 2) << ES);
   localparam logic [NBITS-2:0] MAXMAG = {(NBITS-1){1'b1}};
   localparam logic [NBITS-2:0] MINMAG = {{(NBITS-2){1'b0}}, 1'b1};

   typedef struct packed {
      logic             sgn;
      logic [SBITS-1:0] k;
      logic [ES-1:0]    e;
      logic [FBITS-1:0] frac;
      logic             trunc;
      logic             inf;
      logic             zero;
      logic             sat;
   } s1_t;

   typedef struct packed {
      logic             sgn;
      logic [NBITS-2:0] kept;
      logic             guard;
      logic             sticky;
      logic             inf;
      logic             zero;
      logic             sat;
   } s2_t;

   logic v1, v2, v3;
   logic load1, load2, load3;
   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;

   logic signed [SBITS-1:0] scale_c;
   logic [SBITS-1:0]        shamt;
   logic [BW-1:0]           seed;
   logic [BW-1:0]           body;
   logic                    inc;
   logic [NBITS-2:0]        mag;
   logic [NBITS-1:0]        posit_d;

   logic [NBITS-1:0] posit_q;
   logic             inf_q, zero_q, sat_q;

   // Bubbles collapse: a stage loads whenever it is empty or its contents move on.
   assign load3        = ~v3 | bus.out_ready;
   assign load2        = ~v2 | load3;
   assign load1        = ~v1 | load2;
   assign bus.in_ready = load1;

   always_comb begin
      scale_c = bus.in_scale;
      s1_d    = '0;
      if (bus.in_scale > MAXSCALE) begin
         scale_c  = MAXSCALE;
         s1_d.sat = 1'b1;
      end else if (bus.in_scale < -MAXSCALE) begin
         scale_c  = -MAXSCALE;
         s1_d.sat = 1'b1;
      end
      s1_d.sgn   = bus.in_sgn;
      s1_d.k     = scale_c >>> ES;
      s1_d.e     = scale_c[ES-1:0];
      s1_d.frac  = bus.in_fraction;
      s1_d.trunc = bus.in_truncated;
      s1_d.inf   = bus.in_inf;
      s1_d.zero  = bus.in_zero;
   end

   // Regime built by shifting a 2-bit seed: sign-extension replicates the 1s for k>=0,
   // a logical shift supplies the leading 0s for k<0 (~k == -k-1).
   always_comb begin
      if (s1_q.k[SBITS-1]) begin
         shamt = ~s1_q.k;
         seed  = {2'b01, s1_q.e, s1_q.frac, {(NBITS-1){1'b0}}};
         body  = seed >> shamt;
      end else begin
         shamt = s1_q.k;
         seed  = {2'b10, s1_q.e, s1_q.frac, {(NBITS-1){1'b0}}};
         body  = $signed(seed) >>> shamt;
      end
      s2_d        = '0;
      s2_d.sgn    = s1_q.sgn;
      s2_d.kept   = body[BW-1 -: NBITS-1];
      s2_d.guard  = body[BW-NBITS];
      s2_d.sticky = (|body[BW-NBITS-1:0]) | s1_q.trunc;
      s2_d.inf    = s1_q.inf;
      s2_d.zero   = s1_q.zero;
      s2_d.sat    = s1_q.sat;
   end

   always_comb begin
      inc = (ROUND_MODE == 0) && s2_q.guard && (s2_q.kept[0] || s2_q.sticky)
            && (s2_q.kept != MAXMAG);
      mag = s2_q.kept + (NBITS-1)'(inc);
      if (mag == '0) begin
         mag = MINMAG;
      end
      posit_d = s2_q.sgn ? -{1'b0, mag} : {1'b0, mag};
      if (s2_q.inf) begin
         posit_d = {1'b1, {(NBITS-1){1'b0}}};
      end else if (s2_q.zero) begin
         posit_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         posit_q <= '0;
         inf_q   <= 1'b0;
         zero_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         if (load1) v1 <= bus.in_valid;
         if (load2) v2 <= v1;
         if (load3) begin
            v3 <= v2;
            if (v2) begin
               posit_q <= posit_d;
               inf_q   <= s2_q.inf;
               zero_q  <= s2_q.zero & ~s2_q.inf;
               sat_q   <= s2_q.sat & ~s2_q.inf & ~s2_q.zero;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load1 && bus.in_valid) s1_q <= s1_d;
      if (load2 && v1)           s2_q <= s2_d;
   end

   assign bus.out_valid     = v3;
   assign bus.out_posit     = posit_q;
   assign bus.out_inf       = inf_q;
   assign bus.out_zero      = zero_q;
   assign bus.out_saturated = sat_q;
endmodule
